flag_d0: RTL and testbench

Receive-side zero deletion and flag framing for the bit-stuffed flag stream. Operates on a serial bit stream qualified by a valid strobe: it removes each 0 that follows exactly five consecutive 1s, detects the 01111110 flag and the seven-ones abort, and emits de-stuffed payload bits between flags. It sits between the line-bit recovery stage and the byte/frame assembler, and undoes the zero insertion done on the transmit side.

---
 rtl/flag_d0_if.sv | 27 ++
 rtl/flag_d0.sv | 144 ++++++++++++++
 tb/tb_flag_d0.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/flag_d0_if.sv
// Bit-stream bus for the receive-side de-stuffer / flag framer.
//   master: drives din, din_valid, inr; observes decoded outputs
//   slave : consumes line bits, produces payload bits and frame events
interface flag_d0_if;
   localparam int unsigned LEN_W = 13;

   logic             din;
   logic             din_valid;
   logic             inr;
   logic             dout;
   logic             dout_valid;
   logic             flag_det;
   logic             abort_det;
   logic             frame_end;
   logic [LEN_W-1:0] frame_len;
   logic             align_err;

   modport master (
      output din, din_valid, inr,
      input  dout, dout_valid, flag_det, abort_det, frame_end, frame_len, align_err
   );

   modport slave (
      input  din, din_valid, inr,
      output dout, dout_valid, flag_det, abort_det, frame_end, frame_len, align_err
   );
endinterface

// File: rtl/flag_d0.sv
// Receive-side zero deletion and flag/abort framing.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - flag_d0_if.slave: din/din_valid/inr in; dout/dout_valid,
//           flag_det, abort_det, frame_end, frame_len, align_err out
module flag_d0 (
   input logic       clk,
   input logic       rst_n,
   flag_d0_if.slave  bus
);
   localparam int unsigned ONES_W = 3;
   localparam int unsigned HOLD_W = 7;
   localparam int unsigned CNT_W  = 13;

   localparam logic [ONES_W-1:0] ONES_STUFF = ONES_W'(5);
   localparam logic [ONES_W-1:0] ONES_SIX   = ONES_W'(6);
   localparam logic [ONES_W-1:0] ONES_MAX   = ONES_W'(7);
   localparam logic [ONES_W-1:0] OCC_FULL   = ONES_W'(7);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic {HUNT = 1'b0, DATA = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [ONES_W-1:0]   ones_q, ones_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [ONES_W-1:0]   occ_q, occ_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                dout_q, dout_d;
   logic                dv_q, dv_d;
   logic                flag_q, flag_d;
   logic                abort_q, abort_d;
   logic                fe_q, fe_d;
   logic [CNT_W-1:0]    len_q, len_d;
   logic                align_q, align_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         ones_q  <= '0;
         hold_q  <= '0;
         occ_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         dv_q    <= 1'b0;
         flag_q  <= 1'b0;
         abort_q <= 1'b0;
         fe_q    <= 1'b0;
         len_q   <= '0;
         align_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ones_q  <= ones_d;
         hold_q  <= hold_d;
         occ_q   <= occ_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         flag_q  <= flag_d;
         abort_q <= abort_d;
         fe_q    <= fe_d;
         len_q   <= len_d;
         align_q <= align_d;
      end
   end

   // Bit classification, hold-register shifting and framing decisions
   always_comb begin
      state_d = state_q;
      ones_d  = ones_q;
      hold_d  = hold_q;
      occ_d   = occ_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      flag_d  = 1'b0;
      abort_d = 1'b0;
      fe_d    = 1'b0;
      len_d   = len_q;
      align_d = align_q;

      if (bus.inr) begin
         state_d = HUNT;
         ones_d  = '0;
         hold_d  = '0;
         occ_d   = '0;
         cnt_d   = '0;
         dout_d  = 1'b0;
         len_d   = '0;
         align_d = 1'b0;
      end else if (bus.din_valid) begin
         if (bus.din)
            ones_d = (ones_q == ONES_MAX) ? ONES_MAX : ones_q + ONES_W'(1);
         else
            ones_d = '0;

         if (!bus.din && ones_q == ONES_STUFF) begin
            // stuffed zero: dropped
         end else if (!bus.din && ones_q == ONES_SIX) begin
            // closing 0 of a flag; flag body bits in hold are discarded
            occ_d  = '0;
            flag_d = 1'b1;
            if (state_q == DATA && cnt_q != '0) begin
               fe_d    = 1'b1;
               len_d   = cnt_q;
               align_d = |cnt_q[2:0];
            end
            cnt_d   = '0;
            state_d = DATA;
         end else if (!bus.din && ones_q == ONES_MAX) begin
            // zero terminating an abort run: dropped
         end else if (bus.din && ones_q == ONES_SIX) begin
            occ_d   = '0;
            cnt_d   = '0;
            abort_d = 1'b1;
            state_d = HUNT;
         end else if (bus.din && ones_q == ONES_MAX) begin
            // ones beyond the abort: dropped
         end else begin
            // Newest bit enters at bit 0; once full, bit 6 is the oldest
            hold_d = {hold_q[HOLD_W-2:0], bus.din};
            if (occ_q == OCC_FULL) begin
               if (state_q == DATA) begin
                  dout_d = hold_q[HOLD_W-1];
                  dv_d   = 1'b1;
                  if (cnt_q != CNT_MAX)
                     cnt_d = cnt_q + CNT_W'(1);
               end
            end else begin
               occ_d = occ_q + ONES_W'(1);
            end
         end
      end
   end

   assign bus.dout       = dout_q;
   assign bus.dout_valid = dv_q;
   assign bus.flag_det   = flag_q;
   assign bus.abort_det  = abort_q;
   assign bus.frame_end  = fe_q;
   assign bus.frame_len  = len_q;
   assign bus.align_err  = align_q;
endmodule

// File: tb/tb_flag_d0.sv
// Self-checking bench for flag_d0: expected payload bits are queued as
// stimulus is driven and popped as dout_valid beats appear.
module tb_flag_d0;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   flag_d0_if bus();
   flag_d0 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          n_vec = 0;
   int          n_err = 0;
   logic        exp_q[$];
   logic        exp_bit;
   int          flag_cnt = 0;
   int          abort_cnt = 0;
   int          fe_cnt = 0;
   logic [12:0] fe_len = '0;
   logic        fe_align = 1'b0;

   // Output monitor: scoreboard for payload, event counters for pulses
   always @(negedge clk) begin
      if (bus.dout_valid === 1'b1) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL dout_unexpected: got bit %0b, required no emission", bus.dout);
         end else begin
            exp_bit = exp_q.pop_front();
            if (bus.dout !== exp_bit) begin
               n_err++;
               $display("FAIL dout_bit: got %0b, required %0b", bus.dout, exp_bit);
            end
         end
      end
      if (bus.flag_det === 1'b1)  flag_cnt++;
      if (bus.abort_det === 1'b1) abort_cnt++;
      if (bus.frame_end === 1'b1) begin
         fe_cnt++;
         fe_len   = bus.frame_len;
         fe_align = bus.align_err;
      end
   end

   // Send n bits of v, LSB first; gaps inserts two idle cycles after each bit
   task automatic send_bits(input logic [31:0] v, input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         bus.din       = v[i];
         bus.din_valid = 1'b1;
         @(posedge clk); #1;
         if (gaps) begin
            bus.din_valid = 1'b0;
            bus.din       = 1'($urandom);
            repeat (2) @(posedge clk);
            #1;
         end
      end
      bus.din_valid = 1'b0;
   endtask

   task automatic push_exp(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
   endtask

   task automatic idle(input int n);
      bus.din_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      bus.din = 1'b0; bus.din_valid = 1'b0; bus.inr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({bus.dout, bus.dout_valid, bus.flag_det, bus.abort_det, bus.frame_end, bus.align_err} !== 6'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {bus.dout, bus.dout_valid, bus.flag_det, bus.abort_det, bus.frame_end, bus.align_err});
      end
      n_vec++;
      if (bus.frame_len !== 13'd0) begin
         n_err++; $display("FAIL reset_len: got %0d, required 0", bus.frame_len);
      end
      @(negedge clk); rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_a5;
      int f0, e0;
      f0 = flag_cnt; e0 = fe_cnt;
      send_bits(32'h7E, 8, 1'b0);
      n_vec++;
      if (bus.flag_det !== 1'b1) begin
         n_err++; $display("FAIL a5_flag_latency: got %0b, required 1", bus.flag_det);
      end
      push_exp(32'hA5, 8);
      send_bits(32'hA5, 8, 1'b0);
      send_bits(32'h7E, 8, 1'b0);
      n_vec++;
      if (bus.frame_end !== 1'b1 || bus.frame_len !== 13'd8) begin
         n_err++; $display("FAIL a5_fe_latency: got fe=%0b len=%0d, required fe=1 len=8", bus.frame_end, bus.frame_len);
      end
      idle(3);
      n_vec++;
      if (flag_cnt - f0 != 2) begin
         n_err++; $display("FAIL a5_flags: got %0d, required 2", flag_cnt - f0);
      end
      n_vec++;
      if (fe_cnt - e0 != 1 || fe_len !== 13'd8 || fe_align !== 1'b0) begin
         n_err++; $display("FAIL a5_frame: got n=%0d len=%0d al=%0b, required n=1 len=8 al=0", fe_cnt - e0, fe_len, fe_align);
      end
      n_vec++;
      if (bus.frame_len !== 13'd8 || bus.frame_end !== 1'b0) begin
         n_err++; $display("FAIL a5_len_hold: got len=%0d fe=%0b, required len=8 fe=0", bus.frame_len, bus.frame_end);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL a5_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_stuffed;
      int e0;
      e0 = fe_cnt;
      send_bits(32'h7E, 8, 1'b0);
      push_exp(32'hFF, 8);
      send_bits(32'h1DF, 9, 1'b0);   // 11111 0 111, stuffed zero sixth
      send_bits(32'h7E, 8, 1'b0);
      idle(3);
      n_vec++;
      if (fe_cnt - e0 != 1 || fe_len !== 13'd8) begin
         n_err++; $display("FAIL stuff_frame: got n=%0d len=%0d, required n=1 len=8", fe_cnt - e0, fe_len);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL stuff_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_abort;
      int a0, e0, f0;
      a0 = abort_cnt; e0 = fe_cnt;
      send_bits(32'h7E, 8, 1'b0);
      push_exp(32'h5A, 7);           // eighth bit still held when abort fires
      send_bits(32'h5A, 8, 1'b0);
      send_bits(32'h7F, 7, 1'b0);
      n_vec++;
      if (bus.abort_det !== 1'b1) begin
         n_err++; $display("FAIL abort_latency: got %0b, required 1", bus.abort_det);
      end
      send_bits(32'h2CA, 10, 1'b0);  // hunting: nothing may be emitted
      idle(3);
      f0 = flag_cnt;
      send_bits(32'h7E, 8, 1'b0);
      idle(3);
      n_vec++;
      if (abort_cnt - a0 != 1) begin
         n_err++; $display("FAIL abort_count: got %0d, required 1", abort_cnt - a0);
      end
      n_vec++;
      if (fe_cnt != e0) begin
         n_err++; $display("FAIL abort_no_fe: got %0d frame_end, required 0", fe_cnt - e0);
      end
      n_vec++;
      if (flag_cnt - f0 != 1) begin
         n_err++; $display("FAIL abort_reflag: got %0d, required 1", flag_cnt - f0);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL abort_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back;
      int f0, e0;
      f0 = flag_cnt; e0 = fe_cnt;
      send_bits(32'h3F7E, 15, 1'b0); // 011111101111110
      idle(2);
      n_vec++;
      if (flag_cnt - f0 != 2 || fe_cnt != e0) begin
         n_err++; $display("FAIL b2b_flags: got flags=%0d fe=%0d, required flags=2 fe=0", flag_cnt - f0, fe_cnt - e0);
      end
      push_exp(32'hC3A5, 16);
      send_bits(32'hC3A5, 16, 1'b0);
      send_bits(32'h7E, 8, 1'b0);
      idle(3);
      n_vec++;
      if (fe_cnt - e0 != 1 || fe_len !== 13'd16 || fe_align !== 1'b0) begin
         n_err++; $display("FAIL b2b_frame: got n=%0d len=%0d al=%0b, required n=1 len=16 al=0", fe_cnt - e0, fe_len, fe_align);
      end
   endtask

   task automatic test_gaps;
      int e0;
      e0 = fe_cnt;
      send_bits(32'h7E, 8, 1'b1);
      push_exp(32'hA5, 8);
      send_bits(32'hA5, 8, 1'b1);
      send_bits(32'h7E, 8, 1'b1);
      idle(3);
      n_vec++;
      if (fe_cnt - e0 != 1 || fe_len !== 13'd8 || fe_align !== 1'b0) begin
         n_err++; $display("FAIL gap_frame: got n=%0d len=%0d al=%0b, required n=1 len=8 al=0", fe_cnt - e0, fe_len, fe_align);
      end
      push_exp(32'h135, 10);
      send_bits(32'h135, 10, 1'b1);
      send_bits(32'h7E, 8, 1'b1);
      idle(3);
      n_vec++;
      if (fe_cnt - e0 != 2 || fe_len !== 13'd10 || fe_align !== 1'b1) begin
         n_err++; $display("FAIL gap_align: got n=%0d len=%0d al=%0b, required n=2 len=10 al=1", fe_cnt - e0, fe_len, fe_align);
      end
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL gap_drain: got %0d pending, required 0", exp_q.size());
      end
   endtask

   task automatic test_inr;
      int f0, a0, e0;
      send_bits(32'h7E, 8, 1'b0);
      send_bits(32'hF, 4, 1'b0);
      bus.inr = 1'b1; bus.din = 1'b1; bus.din_valid = 1'b1;
      @(posedge clk); #1;
      bus.inr = 1'b0; bus.din_valid = 1'b0;
      n_vec++;
      if ({bus.dout, bus.dout_valid, bus.flag_det, bus.abort_det, bus.frame_end, bus.align_err} !== 6'b0
          || bus.frame_len !== 13'd0) begin
         n_err++; $display("FAIL inr_clear: got flags=%b len=%0d, required 000000 len=0",
                  {bus.dout, bus.dout_valid, bus.flag_det, bus.abort_det, bus.frame_end, bus.align_err}, bus.frame_len);
      end
      f0 = flag_cnt; a0 = abort_cnt; e0 = fe_cnt;
      send_bits(32'h3, 3, 1'b0);     // 1,1,0: a flag only if ones survived inr
      send_bits(32'h5A5, 12, 1'b0);
      idle(3);
      n_vec++;
      if (flag_cnt != f0 || abort_cnt != a0) begin
         n_err++; $display("FAIL inr_ones: got flags=%0d aborts=%0d, required 0 0", flag_cnt - f0, abort_cnt - a0);
      end
      send_bits(32'h7E, 8, 1'b0);
      push_exp(32'hA5, 8);
      send_bits(32'hA5, 8, 1'b0);
      send_bits(32'h7E, 8, 1'b0);
      idle(3);
      n_vec++;
      if (fe_cnt - e0 != 1 || fe_len !== 13'd8) begin
         n_err++; $display("FAIL inr_refrm: got n=%0d len=%0d, required n=1 len=8", fe_cnt - e0, fe_len);
      end
   endtask

   task automatic test_async_reset;
      send_bits(32'h7E, 8, 1'b0);
      send_bits(32'h15, 5, 1'b0);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.frame_len !== 13'd0 || bus.flag_det !== 1'b0 || bus.dout_valid !== 1'b0) begin
         n_err++; $display("FAIL areset: got len=%0d flag=%0b dv=%0b, required 0 0 0", bus.frame_len, bus.flag_det, bus.dout_valid);
      end
      @(negedge clk); rst_n = 1'b1;
      idle(2);
   endtask

   initial begin
      test_reset();
      test_a5();
      test_stuffed();
      test_abort();
      test_back_to_back();
      test_gaps();
      test_inr();
      test_async_reset();
      idle(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
